// File: rtl/add_sub_top.sv
// Single-precision IEEE-754 adder/subtractor: combinational swap/align/add/
// normalize/round datapath with one output register stage.
module add_sub_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        sign1,
    input  logic [7:0]  exp1,
    input  logic [22:0] sig1,
    input  logic        sign2,
    input  logic [7:0]  exp2,
    input  logic [22:0] sig2,
    input  logic        opcode,
    output logic [31:0] fp_out,
    output logic [2:0]  error
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Index of the leading one, expressed as a left-shift distance
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] lz;
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lz = 5'(26 - i);
        return lz;
    endfunction

    logic        sign2_eff;
    logic        nan1, nan2, inf1, inf2, zero1, zero2;
    logic        swap;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [26:0] ma, mb, mb_al;
    logic [7:0]  shamt;
    logic [53:0] shift_full;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [26:0] mn;
    logic signed [9:0] en, er;
    logic        rnd_up;
    logic [24:0] m25;
    logic [22:0] frac;
    logic [31:0] res;
    logic [2:0]  err;

    always_comb begin
        sign2_eff = sign2 ^ opcode;
        nan1  = (exp1 == 8'hFF) && (sig1 != 23'd0);
        nan2  = (exp2 == 8'hFF) && (sig2 != 23'd0);
        inf1  = (exp1 == 8'hFF) && (sig1 == 23'd0);
        inf2  = (exp2 == 8'hFF) && (sig2 == 23'd0);
        zero1 = (exp1 == 8'd0);
        zero2 = (exp2 == 8'd0);

        // Operand A always carries the larger magnitude
        swap = {exp2, sig2} > {exp1, sig1};
        sa = swap ? sign2_eff : sign1;
        ea = swap ? exp2 : exp1;
        fa = swap ? sig2 : sig1;
        sb = swap ? sign1 : sign2_eff;
        eb = swap ? exp1 : exp2;
        fb = swap ? sig1 : sig2;

        ma = {|ea, fa, 3'b000};
        mb = {|eb, fb, 3'b000};

        // Align B; everything shifted below the sticky slot collapses into it
        shamt      = ea - eb;
        shift_full = {mb, 27'd0} >> shamt;
        if (shamt >= 8'd27) begin
            mb_al = {26'd0, |mb};
        end else begin
            mb_al    = shift_full[53:27];
            mb_al[0] = shift_full[27] | (|shift_full[26:0]);
        end

        // Swap guarantees A >= B, so the difference never goes negative
        if (sa == sb) sum = {1'b0, ma} + {1'b0, mb_al};
        else          sum = {1'b0, ma} - {1'b0, mb_al};

        lz = 5'd0;
        if (sum[27]) begin
            mn = {sum[27:2], sum[1] | sum[0]};
            en = $signed({2'b00, ea}) + 10'sd1;
        end else begin
            lz = lzc27(sum[26:0]);
            mn = sum[26:0] << lz;
            en = $signed({2'b00, ea}) - $signed({5'd0, lz});
        end

        // Round to nearest, ties to even, on G/R/S
        rnd_up = mn[2] & (mn[1] | mn[0] | mn[3]);
        m25    = {1'b0, mn[26:3]} + {24'd0, rnd_up};
        frac   = m25[24] ? m25[23:1] : m25[22:0];
        er     = en + $signed({9'd0, m25[24]});

        res = {sa, er[7:0], frac};
        err = 3'b000;

        if (nan1 || nan2) begin
            res = QNAN;
            err = 3'b100;
        end else if (inf1 && inf2 && (sign1 != sign2_eff)) begin
            res = QNAN;
            err = 3'b100;
        end else if (inf1) begin
            res = {sign1, 8'hFF, 23'd0};
        end else if (inf2) begin
            res = {sign2_eff, 8'hFF, 23'd0};
        end else if (zero1 && zero2) begin
            // Only (-0) + (-0) keeps the negative sign
            res = {sign1 & sign2_eff, 31'd0};
        end else if (zero2) begin
            res = {sign1, exp1, sig1};
        end else if (zero1) begin
            res = {sign2_eff, exp2, sig2};
        end else if (sum == 28'd0) begin
            res = 32'd0;
        end else if (er >= 10'sd255) begin
            res = {sa, 8'hFF, 23'd0};
            err = 3'b001;
        end else if (er <= 10'sd0) begin
            res = {sa, 31'd0};
            err = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_out <= 32'd0;
            error  <= 3'b000;
        end else begin
            fp_out <= res;
            error  <= err;
        end
    end

endmodule

// File: tb/tb_add_sub_top.sv
// Directed-vector bench for add_sub_top with hand-computed expected results.
module tb_add_sub_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        sign1, sign2, opcode;
    logic [7:0]  exp1, exp2;
    logic [22:0] sig1, sig2;
    logic [31:0] fp_out;
    logic [2:0]  error;

    int checks = 0;
    int errors = 0;

    add_sub_top dut (
        .clk(clk), .rst(rst),
        .sign1(sign1), .exp1(exp1), .sig1(sig1),
        .sign2(sign2), .exp2(exp2), .sig2(sig2),
        .opcode(opcode), .fp_out(fp_out), .error(error)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
        {sign1, exp1, sig1} = a;
        {sign2, exp2, sig2} = b;
        opcode = op;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: apply, clock once, check result and flags
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] exp_out, input logic [2:0] exp_err);
        drive(a, b, op);
        @(posedge clk);
        #1;
        chk({tag, ".out"}, fp_out, exp_out);
        chk({tag, ".err"}, {29'd0, error}, {29'd0, exp_err});
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h3F800000, 32'h40400000, 1'b0);
        @(posedge clk);
        drive(32'h7F800000, 32'h7FC00000, 1'b1);
        @(posedge clk);
        #1;
        chk("reset.out", fp_out, 32'h0);
        chk("reset.err", {29'd0, error}, 32'h0);

        rst = 1'b0;
        step("first_after_reset", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        step("mixed_add",  32'h3E99999A, 32'hC0200000, 1'b0, 32'hC00CCCCD, 3'b000);
        step("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        step("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        step("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
        step("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
        step("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b001);
        step("underflow",  32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010);
        step("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        step("nan_plus_one",  32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        step("inf_plus_five", 32'h7F800000, 32'h40A00000, 1'b0, 32'h7F800000, 3'b000);
        step("x_minus_zero",  32'h40A00000, 32'h00000000, 1'b1, 32'h40A00000, 3'b000);
        step("zero_minus_x",  32'h00000000, 32'h40200000, 1'b1, 32'hC0200000, 3'b000);
        step("negzero_sum",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        step("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);

        // Back-to-back: output must hold the previous result until the next edge
        step("b2b0", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);
        drive(32'h40A00000, 32'h40400000, 1'b1);
        #1;
        chk("b2b1.hold", fp_out, 32'h40800000);
        @(posedge clk);
        #1;
        chk("b2b1.out", fp_out, 32'h40000000);
        drive(32'h7F800000, 32'hFF800000, 1'b0);
        #1;
        chk("b2b2.hold", fp_out, 32'h40000000);
        @(posedge clk);
        #1;
        chk("b2b2.out", fp_out, 32'h7FC00000);
        chk("b2b2.err", {29'd0, error}, 32'h4);
        step("b2b3", 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
